mul4_seq: RTL and testbench
===========================

MUL4_SEQ -- requirements
Module: mul4_seq

Interface
REQ-001 The block SHALL have parameter W, default 4, operand width; only 4 is supported because the datapath is the existing 4-bit adder4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  4  multiplicand, unsigned.
REQ-007 b  input  4  multiplier, unsigned.
REQ-008 out_valid  output  1  product p valid.
REQ-009 out_ready  input  1  consumer accepts p.
REQ-010 p  output  8  unsigned product a*b.

Function
REQ-011 The block SHALL be an FSM with states IDLE, RUN, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 Accept: in IDLE with in_valid=1, the edge SHALL load mcand<=a, prod[7:4]<=0, prod[3:0]<=b, step<=0, state<=RUN.
REQ-014 Each RUN cycle: if prod[0]=1, {c,s}=prod[7:4]+mcand via adder4 (carry-in 0); else {c,s}={0,prod[7:4]}; prod<={c,s,prod[3:1]}; step<=step+1.
REQ-015 RUN SHALL last exactly 4 cycles (step 0..3); the edge with step=3 SHALL move to DONE.
REQ-016 Latency: accept at edge k, out_valid SHALL be 1 from the cycle after edge k+4 (5 cycles after the accept cycle).
REQ-017 p SHALL equal prod continuously; in DONE it SHALL equal a*b of the accepted pair, full 8 bits, no overflow possible (max 15*15=225).
REQ-018 In DONE with out_ready=0, p and out_valid SHALL hold stable indefinitely.
REQ-019 In DONE with out_ready=1, the edge SHALL move to IDLE; next accept earliest one cycle later (throughput one product per 6 cycles).
REQ-020 in_valid, a, b SHALL be ignored outside IDLE; operands are captured only at the accept edge.
REQ-021 out_ready SHALL be ignored outside DONE.
REQ-022 step SHALL be 2 bits and wrap is never reached because RUN exits at step=3.

Reset
REQ-023 rst=1 SHALL immediately, without clock, force state=IDLE, prod=0, mcand=0, step=0.
REQ-024 During and after reset: in_ready=1, out_valid=0, p=8'h00.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation; no partial product SHALL ever appear with out_valid=1.
REQ-026 First accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 Package mul4_pkg SHALL hold the state typedef (IDLE, RUN, DONE), constants W=4 and STEPS=4.
REQ-028 Exactly one sub-module instance SHALL be used: the existing adder4, combinational, fed by prod[7:4] and mcand.
REQ-029 The add/no-add selection SHALL be a mux on adder4 output in mul4_seq, not a second adder.

Verification
REQ-030 a=13, b=11, in_valid pulse, out_ready=1 -> out_valid high exactly 5 cycles after accept, p=8'd143, then in_ready=1 next cycle.
REQ-031 a=15, b=15 -> p=8'd225; a=0, b=9 -> p=0; a=7, b=0 -> p=0.
REQ-032 out_ready held 0 for 10 cycles in DONE with a=6, b=5 -> p=8'd30 and out_valid stable throughout, in_ready=0; release -> IDLE.
REQ-033 in_valid held 1 with changing a/b during RUN -> ignored, result uses operands from accept edge only.
REQ-034 rst pulsed asynchronously (between edges) in RUN step 2 -> in_ready=1, out_valid=0, p=0 immediately; following a=3, b=4 -> p=8'd12.
REQ-035 Back-to-back random 200 pairs with random out_ready stalls -> every p equals a*b in order, no dropped or duplicated results.

Source files
------------

// File: rtl/mul4_pkg.sv
// Shared types and constants for the sequential 4x4 shift-add multiplier.
package mul4_pkg;

    // Operand width supported by the adder4 datapath.
    localparam int W = 4;

    // Number of shift-add iterations, one per multiplier bit.
    localparam int STEPS = 4;

    // Controller states: waiting for operands, iterating, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder4.sv
// Combinational 4-bit ripple adder with carry-in and carry-out.
module adder4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    // Single 5-bit sum split into carry and sum bits.
    always_comb begin
        {cout, s} = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    end

endmodule

// File: rtl/mul4_seq.sv
// Sequential unsigned multiplier: one shift-add step per clock over four
// cycles, with valid/ready handshakes on operand input and product output.
// Only W=4 is meaningful because the datapath is the fixed-width adder4.
module mul4_seq
    import mul4_pkg::*;
#(
    parameter int W = mul4_pkg::W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p
);

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   mcand;
    logic [2*W-1:0] prod;
    logic [1:0]     step;
    logic [W-1:0]   sum;
    logic           carry;
    logic [W:0]     upper_next;
    logic           last_step;

    // The single adder always sees the running upper half and the multiplicand;
    // whether its result is used is decided by the mux below.
    adder4 u_adder (
        .x    (prod[2*W-1:W]),
        .y    (mcand),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

    assign last_step = (step == 2'(STEPS - 1));
    assign p         = prod;

    // Add/no-add select on the current multiplier LSB, carry kept as bit W.
    always_comb begin
        upper_next = {1'b0, prod[2*W-1:W]};
        if (prod[0]) begin
            upper_next = {carry, sum};
        end
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, then shift the partial product
    // right each RUN cycle; prod holds steady in IDLE and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod  <= '0;
            mcand <= '0;
            step  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        prod  <= {{W{1'b0}}, b};
                        step  <= 2'd0;
                    end
                end
                RUN: begin
                    prod <= {upper_next, prod[W-1:1]};
                    step <= step + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul4_seq.sv
// Scoreboard bench for mul4_seq: directed corner cases plus randomized
// back-to-back traffic with random output stalls.
module tb_mul4_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] p;

    typedef struct {
        int prod;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   pushes = 0;
    int   pops = 0;
    int   cyc = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random stalls, 2: held low

    logic       prev_ov = 1'b0;
    logic       prev_or = 1'b0;
    logic [7:0] prev_p = 8'd0;

    mul4_seq #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Consumer: drives out_ready shortly after each edge.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Monitor: pops the scoreboard on each completed output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 16'(out_valid), 16'd0);
                end else begin
                    check("latency_edges", 16'(cyc - sb[0].acc_cyc), 16'd4);
                end
                check("in_ready_in_done", 16'(in_ready), 16'd0);
            end
            if (prev_ov && !prev_or) begin
                check("stall_hold_valid", 16'(out_valid), 16'd1);
                check("stall_hold_p", 16'(p), 16'(prev_p));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                pops++;
                check("product", 16'(p), 16'(e.prod));
                $display("[TB] result #%0d p=%0d expected=%0d", pops, p, e.prod);
            end
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_p  = p;
        end else begin
            prev_ov = 1'b0;
            prev_or = 1'b0;
        end
    end

    // Present one operand pair; returns one time unit after the accept edge.
    task automatic send(input logic [3:0] va, input logic [3:0] vb, input bit garbage);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            timeout("wait_in_ready");
            return;
        end
        in_valid = 1'b1;
        a = va;
        b = vb;
        @(posedge clk);
        #1;
        sb.push_back('{prod: int'(va) * int'(vb), acc_cyc: cyc});
        pushes++;
        $display("[TB] accept a=%0d b=%0d", va, vb);
        if (garbage) begin
            repeat (3) begin
                a = 4'($urandom);
                b = 4'($urandom);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) timeout(name);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) timeout(name);
    endtask

    initial begin
        // Reset state, asynchronous: no clock edge has occurred yet.
        #1;
        check("reset_in_ready", 16'(in_ready), 16'd1);
        check("reset_out_valid", 16'(out_valid), 16'd0);
        check("reset_p", 16'(p), 16'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // 13*11 with immediate consumer; accept on first edge after reset.
        send(4'd13, 4'd11, 1'b0);
        wait_out("wait_13x11");
        check("p_13x11", 16'(p), 16'd143);
        @(posedge clk);
        #1;
        check("idle_after_handshake_in_ready", 16'(in_ready), 16'd1);
        check("idle_after_handshake_out_valid", 16'(out_valid), 16'd0);

        // Corner operands.
        send(4'd15, 4'd15, 1'b0);
        send(4'd0, 4'd9, 1'b0);
        send(4'd7, 4'd0, 1'b0);
        wait_drain("drain_corners");

        // Long output stall holds result and status.
        ready_mode = 2;
        send(4'd6, 4'd5, 1'b0);
        wait_out("wait_6x5");
        repeat (10) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 16'(out_valid), 16'd1);
            check("stall_in_ready", 16'(in_ready), 16'd0);
            check("stall_p", 16'(p), 16'd30);
        end
        ready_mode = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("release_in_ready", 16'(in_ready), 16'd1);

        // Operand changes during RUN must not disturb the result.
        send(4'd10, 4'd12, 1'b1);
        wait_drain("drain_garbage");

        // Asynchronous reset in RUN step 2 aborts the operation.
        send(4'd9, 4'd9, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 16'(in_ready), 16'd1);
        check("abort_out_valid", 16'(out_valid), 16'd0);
        check("abort_p", 16'(p), 16'd0);
        sb.delete();
        pushes--;
        #3;
        rst = 1'b0;
        send(4'd3, 4'd4, 1'b0);
        wait_out("wait_3x4");
        check("p_3x4", 16'(p), 16'd12);
        wait_drain("drain_after_reset");

        // Randomized back-to-back traffic with random stalls.
        ready_mode = 1;
        for (int i = 0; i < 200; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(4'($urandom), 4'($urandom), 1'($urandom_range(0, 7) == 0));
        end
        wait_drain("drain_random");
        check("results_count", 16'(pops), 16'(pushes));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
